// File: rtl/dense_mac_layer_if.sv
// Handshake and weight-ROM bundle for the dense layer stage.
// The slave modport is the dense layer; the master modport is its environment.
interface dense_mac_layer_if #(
   parameter int unsigned IN_SIZE  = 40,
   parameter int unsigned OUT_SIZE = 10,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WEIGHT_W = 16,
   parameter int unsigned WADDR_W  = $clog2(IN_SIZE * OUT_SIZE)
);
   logic                                  flatten_valid_i;
   logic [0:IN_SIZE-1][DATA_W-1:0]        flatten_data_i;
   logic                                  flatten_ready_o;
   logic                                  weight_en_o;
   logic [WADDR_W-1:0]                    weight_addr_o;
   logic [WEIGHT_W-1:0]                   weight_data_i;
   logic                                  dense_valid_o;
   logic [0:OUT_SIZE-1][DATA_W-1:0]       dense_data_o;
   logic                                  dense_ready_i;

   modport slave (
      input  flatten_valid_i, flatten_data_i, weight_data_i, dense_ready_i,
      output flatten_ready_o, weight_en_o, weight_addr_o, dense_valid_o, dense_data_o
   );

   modport master (
      output flatten_valid_i, flatten_data_i, weight_data_i, dense_ready_i,
      input  flatten_ready_o, weight_en_o, weight_addr_o, dense_valid_o, dense_data_o
   );
endinterface

// File: rtl/dense_mac_layer.sv
// Dense layer: one time-multiplexed signed MAC walks every neuron's weight row from
// an external synchronous ROM, then requantises, saturates and optionally ReLUs each result.
module dense_mac_layer #(
   parameter int unsigned IN_SIZE   = 40,
   parameter int unsigned OUT_SIZE  = 10,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned WEIGHT_W  = 16,
   parameter int unsigned FRAC_BITS = 8,
   parameter int unsigned ACC_W     = 40,
   parameter int unsigned RELU_EN   = 1,
   parameter int unsigned WADDR_W   = $clog2(IN_SIZE * OUT_SIZE)
) (
   input logic               clk_i,
   input logic               rst_i,
   dense_mac_layer_if.slave  bus
);

   localparam int unsigned IDX_W  = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
   localparam int unsigned NEU_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   if (ACC_W < DATA_W + WEIGHT_W + $clog2(IN_SIZE)) begin : g_acc_w_chk
      $error("dense_mac_layer: ACC_W too narrow for worst-case accumulation");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_DRAIN,
      S_STORE,
      S_OUT
   } state_e;

   state_e                          state_q, state_d;
   logic [0:IN_SIZE-1][DATA_W-1:0]  x_q, x_d;
   logic [IDX_W-1:0]                i_q, i_d;
   logic [IDX_W-1:0]                ip_q, ip_d;
   logic                            rd_q, rd_d;
   logic [NEU_W-1:0]                j_q, j_d;
   logic [WADDR_W-1:0]              addr_q, addr_d;
   logic signed [ACC_W-1:0]         acc_q, acc_d;
   logic [0:OUT_SIZE-1][DATA_W-1:0] res_q, res_d;
   logic                            ready_q, ready_d;
   logic                            en_q, en_d;
   logic                            valid_q, valid_d;

   logic signed [PROD_W-1:0]        prod;
   logic signed [ACC_W-1:0]         shifted;
   logic signed [DATA_W-1:0]        r;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      i_d     = i_q;
      ip_d    = i_q;
      rd_d    = (state_q == S_MAC);
      j_d     = j_q;
      addr_d  = addr_q;
      acc_d   = acc_q;
      res_d   = res_q;

      prod    = PROD_W'($signed(x_q[ip_q])) * PROD_W'($signed(bus.weight_data_i));
      shifted = acc_q >>> FRAC_BITS;

      r = DATA_W'(shifted);
      if (shifted > SAT_MAX) begin
         r = DATA_W'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
         r = DATA_W'(SAT_MIN);
      end
      if ((RELU_EN != 0) && r[DATA_W-1]) begin
         r = '0;
      end

      // ROM data returns one cycle after the read, so accumulate against the previous index
      if (rd_q) begin
         acc_d = acc_q + ACC_W'(prod);
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.flatten_valid_i && ready_q) begin
               x_d     = bus.flatten_data_i;
               i_d     = '0;
               j_d     = '0;
               addr_d  = '0;
               acc_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            addr_d = addr_q + WADDR_W'(1);
            i_d    = i_q + IDX_W'(1);
            if (i_q == IDX_W'(IN_SIZE - 1)) begin
               i_d     = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_d = S_STORE;
         end
         S_STORE: begin
            res_d[j_q] = r;
            acc_d      = '0;
            i_d        = '0;
            if (j_q == NEU_W'(OUT_SIZE - 1)) begin
               state_d = S_OUT;
            end else begin
               j_d     = j_q + NEU_W'(1);
               state_d = S_MAC;
            end
         end
         S_OUT: begin
            if (bus.dense_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      en_d    = (state_d == S_MAC);
      valid_d = (state_d == S_OUT);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         i_q     <= '0;
         ip_q    <= '0;
         rd_q    <= 1'b0;
         j_q     <= '0;
         addr_q  <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         ready_q <= 1'b1;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         i_q     <= i_d;
         ip_q    <= ip_d;
         rd_q    <= rd_d;
         j_q     <= j_d;
         addr_q  <= addr_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         ready_q <= ready_d;
         en_q    <= en_d;
         valid_q <= valid_d;
      end
   end

   // Ready is masked while reset is held so no vector can be taken in a reset cycle
   assign bus.flatten_ready_o = ready_q & ~rst_i;
   assign bus.weight_en_o     = en_q;
   assign bus.weight_addr_o   = addr_q;
   assign bus.dense_valid_o   = valid_q;
   assign bus.dense_data_o    = res_q;

endmodule

// File: tb/tb_dense_mac_layer.sv
// Directed bench for dense_mac_layer: three small instances (plain, ReLU, Q8 fixed point)
// share handshake stimulus, each with its own weight ROM model.
module tb_dense_mac_layer;

   localparam int unsigned IN  = 4;
   localparam int unsigned OUT = 2;
   localparam int unsigned DW  = 8;
   localparam int unsigned WW  = 16;
   localparam int unsigned AW  = 3;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic out_ready;

   int xa [4];
   int xc [4];
   int wab [8];
   int wc [8];

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] en_mask;
   int          addr_log [$];
   int          busy_bad;

   always #5 clk = ~clk;

   dense_mac_layer_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .WEIGHT_W(WW), .WADDR_W(AW)) ifa ();
   dense_mac_layer_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .WEIGHT_W(WW), .WADDR_W(AW)) ifb ();
   dense_mac_layer_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .WEIGHT_W(WW), .WADDR_W(AW)) ifc ();

   dense_mac_layer #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .WEIGHT_W(WW), .FRAC_BITS(0),
                     .ACC_W(40), .RELU_EN(0), .WADDR_W(AW))
      u_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
   dense_mac_layer #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .WEIGHT_W(WW), .FRAC_BITS(0),
                     .ACC_W(40), .RELU_EN(1), .WADDR_W(AW))
      u_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
   dense_mac_layer #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .WEIGHT_W(WW), .FRAC_BITS(8),
                     .ACC_W(40), .RELU_EN(0), .WADDR_W(AW))
      u_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

   assign ifa.flatten_valid_i = in_valid;
   assign ifb.flatten_valid_i = in_valid;
   assign ifc.flatten_valid_i = in_valid;
   assign ifa.dense_ready_i   = out_ready;
   assign ifb.dense_ready_i   = out_ready;
   assign ifc.dense_ready_i   = out_ready;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         ifa.flatten_data_i[k] = DW'(xa[k]);
         ifb.flatten_data_i[k] = DW'(xa[k]);
         ifc.flatten_data_i[k] = DW'(xc[k]);
      end
   end

   // Synchronous weight ROMs: data one cycle after enable
   always @(posedge clk) begin
      if (ifa.weight_en_o) ifa.weight_data_i <= WW'(wab[ifa.weight_addr_o]);
      if (ifb.weight_en_o) ifb.weight_data_i <= WW'(wab[ifb.weight_addr_o]);
      if (ifc.weight_en_o) ifc.weight_data_i <= WW'(wc[ifc.weight_addr_o]);
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_res(input string t, input int a0, input int a1, input int b0,
                            input int b1, input int c0, input int c1);
      chk({t, "_a0"}, $signed(ifa.dense_data_o[0]), a0);
      chk({t, "_a1"}, $signed(ifa.dense_data_o[1]), a1);
      chk({t, "_b0"}, $signed(ifb.dense_data_o[0]), b0);
      chk({t, "_b1"}, $signed(ifb.dense_data_o[1]), b1);
      chk({t, "_c0"}, $signed(ifc.dense_data_o[0]), c0);
      chk({t, "_c1"}, $signed(ifc.dense_data_o[1]), c1);
   endtask

   task automatic check_addr(input string t);
      chk({t, "_en_mask"}, en_mask, 32'h0000_079E);
      chk({t, "_addr_cnt"}, addr_log.size(), 8);
      for (int k = 0; k < addr_log.size() && k < 8; k++) begin
         chk($sformatf("%s_addr%0d", t, k), addr_log[k], k);
      end
   endtask

   // Offer one vector, scramble the inputs after acceptance, and walk cycles C0+1.. until
   // output valid (lat = cycles after C0) or until stop_at is reached.
   task automatic run_vec(input int stop_at, output int lat);
      lat      = -1;
      en_mask  = '0;
      busy_bad = 0;
      addr_log.delete();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      xa = '{50, 50, 50, 50};
      xc = '{-7, -7, -7, -7};
      for (int n = 1; n <= 100; n++) begin
         if (stop_at != 0 && n == stop_at) return;
         if (ifa.dense_valid_o) begin
            lat = n;
            return;
         end
         if (ifa.weight_en_o) begin
            if (n < 32) en_mask[n] = 1'b1;
            addr_log.push_back(int'(ifa.weight_addr_o));
         end
         if (ifa.flatten_ready_o) busy_bad++;
         step();
      end
   endtask

   task automatic load_set1();
      wab = '{1, 1, 1, 1, 1, -1, 1, -1};
      xa  = '{1, 2, 3, 4};
      wc  = '{256, 256, 256, 256, -256, -256, -256, -256};
      xc  = '{127, 127, 127, 127};
   endtask

   initial begin
      int   lat;
      int   bp_bad;
      logic [0:OUT-1][DW-1:0] held;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      load_set1();
      step();
      step();

      chk("rst_ready", ifa.flatten_ready_o, 0);
      chk("rst_valid", ifa.dense_valid_o, 0);
      chk("rst_en",    ifa.weight_en_o, 0);
      chk("rst_addr",  ifa.weight_addr_o, 0);
      check_res("rst", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk("idle_ready", ifa.flatten_ready_o, 1);

      // Vector 1: identity/ReLU/saturation, then backpressure
      run_vec(0, lat);
      chk("v1_latency", lat, 13);
      chk("v1_busy_ready", busy_bad, 0);
      check_addr("v1");
      check_res("v1", 10, -2, 10, 0, 127, -128);

      held   = ifc.dense_data_o;
      bp_bad = 0;
      repeat (20) begin
         step();
         if (!ifa.dense_valid_o || ifa.flatten_ready_o || ifa.weight_en_o ||
             ifc.dense_data_o !== held)
            bp_bad++;
      end
      chk("bp_hold", bp_bad, 0);
      out_ready = 1'b1;
      step();
      chk("bp_valid_drop", ifa.dense_valid_o, 0);
      chk("bp_ready_back", ifa.flatten_ready_o, 1);
      out_ready = 1'b0;
      check_res("v1_held", 10, -2, 10, 0, 127, -128);

      // Vector 2: mixed signs, floor of -1/256, ready already high at OUT
      wab = '{2, 0, 1, -1, 0, 3, 0, 0};
      xa  = '{-3, 5, 0, 2};
      wc  = '{1, 0, 0, 0, 0, 0, 0, 0};
      xc  = '{-1, 0, 0, 0};
      out_ready = 1'b1;
      run_vec(0, lat);
      chk("v2_latency", lat, 13);
      check_res("v2", -8, 15, 0, 15, -1, 0);
      step();
      chk("v2_out_one_cycle", ifa.dense_valid_o, 0);
      chk("v2_ready_back", ifa.flatten_ready_o, 1);
      out_ready = 1'b0;

      // Reset during MAC of neuron 1, then a fresh vector
      load_set1();
      run_vec(8, lat);
      chk("mid_en_before_rst", ifa.weight_en_o, 1);
      rst = 1'b1;
      step();
      chk("mid_rst_ready", ifa.flatten_ready_o, 0);
      rst = 1'b0;
      #1;
      chk("mid_idle_ready", ifa.flatten_ready_o, 1);
      chk("mid_valid", ifa.dense_valid_o, 0);
      chk("mid_en",    ifa.weight_en_o, 0);
      chk("mid_addr",  ifa.weight_addr_o, 0);
      check_res("mid", 0, 0, 0, 0, 0, 0);

      load_set1();
      run_vec(0, lat);
      chk("v3_latency", lat, 13);
      check_addr("v3");
      check_res("v3", 10, -2, 10, 0, 127, -128);
      out_ready = 1'b1;
      step();
      chk("v3_valid_drop", ifa.dense_valid_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
